// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR stream constants and the stored beat type
package fir_pkg;
  localparam int FIR_DATA_W = 32;
  localparam int FIR_OUT_FIFO_DEPTH = 8;
  typedef struct packed {
    logic [FIR_DATA_W-1:0] data;
    logic                  last;
  } axis_beat_t;
endpackage

// File: rtl/fir_axis_out_fifo_if.sv
// fir_axis_out_fifo_if: AXI-Stream beat channel (valid/ready/data/last)
interface fir_axis_out_fifo_if import fir_pkg::*; #(parameter int DATA_W = FIR_DATA_W);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;
  modport master(output tvalid, tdata, tlast, input tready);
  modport slave(input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/fir_fifo_mem.sv
// fir_fifo_mem: 1-write/1-read register array of beats, async read, no reset
module fir_fifo_mem import fir_pkg::*; #(
  parameter int DEPTH = FIR_OUT_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  axis_beat_t        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output axis_beat_t        rdata
);
  axis_beat_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fir_axis_out_fifo.sv
// fir_axis_out_fifo: FWFT output FIFO between FIR Y stream and WB bridge.
// Define FIR_OUT_FIFO_STATS_EN to add stats_clr/hi_water/frame_cnt.
module fir_axis_out_fifo import fir_pkg::*; #(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH = FIR_OUT_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                axis_clk,
  input  logic                axis_rst_n,
  fir_axis_out_fifo_if.slave  s_axis,
  fir_axis_out_fifo_if.master m_axis,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                empty
`ifdef FIR_OUT_FIFO_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [ADDR_W:0]     hi_water,
  output logic [15:0]         frame_cnt
`endif
);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              rst_q, push, pop;
  axis_beat_t        rd_beat;
  assign full  = count == (ADDR_W+1)'(DEPTH);
  assign empty = count == '0;
  // rst_q keeps the producer stalled for one cycle after reset release
  assign s_axis.tready = ~full & rst_q;
  assign push = s_axis.tvalid & s_axis.tready;
  assign pop  = m_axis.tvalid & m_axis.tready;
  assign m_axis.tvalid = ~empty;
  assign m_axis.tdata  = empty ? '0 : rd_beat.data;
  assign m_axis.tlast  = ~empty & rd_beat.last;
  assign count_nxt = count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
  fir_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (axis_clk),
    .we    (push & axis_rst_n),
    .waddr (wr_ptr),
    .wdata ({s_axis.tdata, s_axis.tlast}),
    .raddr (rd_ptr),
    .rdata (rd_beat)
  );
  always_ff @(posedge axis_clk) begin
    rst_q <= axis_rst_n;
    if (!axis_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end
`ifdef FIR_OUT_FIFO_STATS_EN
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n || stats_clr) begin
      hi_water  <= '0;
      frame_cnt <= '0;
    end else begin
      if (count_nxt > hi_water) hi_water <= count_nxt;
      if (pop && m_axis.tlast) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fir_axis_out_fifo.sv
// tb_fir_axis_out_fifo: table vectors plus a scoreboard for the output FIFO
module tb_fir_axis_out_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] count;
  logic       full, empty;
  int         total = 0, bad = 0, sb_pops = 0;
  logic [32:0] sb[$];
`ifdef FIR_OUT_FIFO_STATS_EN
  logic        stats_clr = 1'b0;
  logic [3:0]  hi_water;
  logic [15:0] frame_cnt;
`endif
  always #5 clk = ~clk;
  fir_axis_out_fifo_if #(.DATA_W(32)) s_if ();
  fir_axis_out_fifo_if #(.DATA_W(32)) m_if ();
  fir_axis_out_fifo dut (
    .axis_clk   (clk),
    .axis_rst_n (rst_n),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .count      (count),
    .full       (full),
    .empty      (empty)
`ifdef FIR_OUT_FIFO_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .hi_water   (hi_water),
    .frame_cnt  (frame_cnt)
`endif
  );
  typedef struct {
    logic        sv;
    logic [31:0] d;
    logic        l;
    logic        mr;
    logic [3:0]  cnt;
    logic [31:0] hd;
    logic        hl;
  } vec_t;
  vec_t vecs[13];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic sv, input logic [31:0] d, input logic l, input logic mr);
    s_if.tvalid = sv;
    s_if.tdata  = d;
    s_if.tlast  = l;
    m_if.tready = mr;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Inputs are stable from posedge+1 to the next posedge, so negedge sees the coming handshake
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else begin
      if (m_if.tvalid && m_if.tready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got %h expected none", {m_if.tlast, m_if.tdata});
        end else begin
          chk("sb_beat", {31'd0, m_if.tlast, m_if.tdata}, {31'd0, sb.pop_front()});
          sb_pops++;
        end
      end
      if (s_if.tvalid && s_if.tready) sb.push_back({s_if.tlast, s_if.tdata});
    end
  end
  initial begin
    vecs[0]  = '{1, 32'h11, 0, 0, 1, 32'h11, 0};
    vecs[1]  = '{1, 32'h22, 0, 0, 2, 32'h11, 0};
    vecs[2]  = '{1, 32'h33, 0, 0, 3, 32'h11, 0};
    vecs[3]  = '{0, 32'h0,  0, 1, 2, 32'h22, 0};
    vecs[4]  = '{0, 32'h0,  0, 1, 1, 32'h33, 0};
    vecs[5]  = '{0, 32'h0,  0, 1, 0, 32'h0,  0};
    vecs[6]  = '{0, 32'h0,  0, 0, 0, 32'h0,  0};
    vecs[7]  = '{1, 32'h01, 0, 0, 1, 32'h01, 0};
    vecs[8]  = '{1, 32'hA5, 1, 0, 2, 32'h01, 0};
    vecs[9]  = '{1, 32'h02, 0, 1, 2, 32'hA5, 1};
    vecs[10] = '{0, 32'h0,  0, 0, 2, 32'hA5, 1};
    vecs[11] = '{0, 32'h0,  0, 1, 1, 32'h02, 0};
    vecs[12] = '{0, 32'h0,  0, 1, 0, 32'h0,  0};
    drive(0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_tready", s_if.tready, 0);
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tdata", m_if.tdata, 0);
    chk("rst_tlast", m_if.tlast, 0);
    rst_n = 1'b1;
    chk("rel_tready0", s_if.tready, 0);
    tick();
    chk("rel_tready1", s_if.tready, 1);
    chk("rel_tvalid", m_if.tvalid, 0);
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].sv, vecs[i].d, vecs[i].l, vecs[i].mr);
      tick();
      chk($sformatf("vec%0d_cnt", i), count, vecs[i].cnt);
      chk($sformatf("vec%0d_valid", i), m_if.tvalid, vecs[i].cnt != 0);
      chk($sformatf("vec%0d_data", i), m_if.tdata, vecs[i].hd);
      chk($sformatf("vec%0d_last", i), m_if.tlast, vecs[i].hl);
    end
`ifdef FIR_OUT_FIFO_STATS_EN
    chk("frame_cnt", frame_cnt, 1);
`endif
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h100 + i, 0, 0);
      tick();
    end
    chk("fill_full", full, 1);
    chk("fill_tready", s_if.tready, 0);
    chk("fill_count", count, 8);
    drive(1, 32'h999, 0, 0);
    tick();
    chk("ninth_held_count", count, 8);
    chk("ninth_held_head", m_if.tdata, 32'h100);
    drive(1, 32'h999, 0, 1);
    tick();
    chk("full_pop_count", count, 7);
    chk("full_pop_tready", s_if.tready, 1);
    drive(1, 32'h999, 0, 0);
    tick();
    chk("ninth_acc_count", count, 8);
`ifdef FIR_OUT_FIFO_STATS_EN
    chk("hi_water", hi_water, 8);
`endif
    drive(0, 0, 0, 1);
    for (int i = 0; i < 20 && count != 0; i++) tick();
    chk("drain_count", count, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h4000 + i, 0, 1);
      tick();
      if (i == 0 || i == 19) chk($sformatf("stream%0d_cnt", i), count, 1);
    end
    drive(0, 0, 0, 1);
    tick();
    chk("stream_end_cnt", count, 0);
    chk("sb_pops", sb_pops, 35);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h500 + i, 0, 0);
      tick();
    end
    chk("pre_rst_count", count, 5);
    drive(1, 32'h5FF, 0, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_tvalid", m_if.tvalid, 0);
    chk("mid_rst_tdata", m_if.tdata, 0);
`ifdef FIR_OUT_FIFO_STATS_EN
    chk("mid_rst_hi_water", hi_water, 0);
`endif
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    chk("post_rst_count", count, 0);
    drive(1, 32'h77, 0, 0);
    tick();
    chk("post_rst_head", m_if.tdata, 32'h77);
    chk("post_rst_cnt1", count, 1);
    drive(0, 0, 0, 1);
    tick();
    chk("post_rst_empty", empty, 1);
    chk("post_rst_tdata0", m_if.tdata, 0);
    drive(0, 0, 0, 0);
    tick();
    chk("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
